// File: rtl/fft_result_reader_if.sv
// Output stream of fft_result_reader: one FFT bin per beat on a valid/ready handshake.
interface fft_result_reader_if #(
    parameter int LEVEL = 12
);
    logic             m_valid;
    logic             m_ready;
    logic [63:0]      m_data;
    logic [LEVEL-1:0] m_index;
    logic             m_last;

    modport master (output m_valid, m_data, m_index, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_index, m_last, output m_ready);
endinterface

// File: rtl/fft_result_reader.sv
// Drains a finished transform from the FFT core's result memory into a valid/ready stream,
// buffering returned words in a small FIFO so downstream backpressure never drops data.
module fft_result_reader #(
    parameter int  N          = 4096,
    parameter int  RD_LAT     = 1,
    parameter int  FIFO_DEPTH = 4,
    parameter int  BITREV     = 0,
    localparam int LEVEL      = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                fft_done_i,
    input  logic                fft_busy_i,
    output logic                read_en_o,
    output logic [LEVEL-1:0]    read_addr1_o,
    output logic [LEVEL-1:0]    read_addr2_o,
    input  logic [63:0]         fft_data_i,
    fft_result_reader_if.master m_if,
    output logic                busy_o,
    output logic                abort_o
);

    localparam int               PTR_W  = $clog2(FIFO_DEPTH);
    localparam int               CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int               SUM_W  = CNT_W + 2;
    localparam logic [LEVEL-1:0] K_LAST = LEVEL'(N - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [LEVEL-1:0]      k_q, k_d;
    logic [RD_LAT-1:0]     tag_v_q, tag_v_d;
    logic [LEVEL-1:0]      tag_idx_q [RD_LAT];
    logic [LEVEL-1:0]      tag_idx_d [RD_LAT];
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [63:0]           data_q [FIFO_DEPTH];
    logic [LEVEL-1:0]      idx_q  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_q;
    logic                  abort_q;

    logic                  start_ok, abort_evt, credit_ok, issue, push, pop;
    logic [SUM_W-1:0]      inflight;

    function automatic logic [LEVEL-1:0] bitrev(input logic [LEVEL-1:0] v);
        logic [LEVEL-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LEVEL; i++) r[i] = v[LEVEL-1-i];
        return r;
    endfunction

    // Entry requires done=1/busy=0, so the level check here sees exactly the falling/rising edge.
    assign start_ok  = start_i && fft_done_i && !fft_busy_i;
    assign abort_evt = (state_q != IDLE) && (!fft_done_i || fft_busy_i);
    assign pop       = (count_q != '0) && m_if.m_ready;
    assign push      = tag_v_q[RD_LAT-1] && !abort_evt;

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) inflight = inflight + SUM_W'(tag_v_q[i]);
    end

    // A pop at this edge frees its slot in time for the new issue, allowing depth RD_LAT+1 to sustain.
    assign credit_ok = (SUM_W'(count_q) + inflight) < (SUM_W'(FIFO_DEPTH) + SUM_W'(pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = DRAIN;
            DRAIN:   if (abort_evt) state_d = IDLE;
                     else if (issue && k_q == K_LAST) state_d = FLUSH;
            FLUSH:   if (abort_evt) state_d = IDLE;
                     else if (inflight == '0 && count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        read_en_o = (state_q != IDLE);
        busy_o    = (state_q != IDLE);
        issue     = (state_q == DRAIN) && !abort_evt && credit_ok;
    end

    always_comb begin
        k_d = k_q;
        if (state_q == IDLE && start_ok) k_d = '0;
        else if (issue)                  k_d = k_q + 1'b1;

        tag_v_d = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) tag_idx_d[i] = tag_idx_q[i];
        tag_v_d[0]   = issue;
        tag_idx_d[0] = k_q;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_v_d[i]   = tag_v_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end
        if (abort_evt) tag_v_d = '0;
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
        if (abort_evt) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q      <= '0;
            tag_v_q  <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            abort_q  <= 1'b0;
            for (int unsigned i = 0; i < RD_LAT; i++) tag_idx_q[i] <= '0;
        end else begin
            k_q      <= k_d;
            tag_v_q  <= tag_v_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            abort_q  <= abort_evt;
            for (int unsigned i = 0; i < RD_LAT; i++) tag_idx_q[i] <= tag_idx_d[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                idx_q[i]  <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= fft_data_i;
            idx_q[wr_ptr_q]  <= tag_idx_q[RD_LAT-1];
            last_q[wr_ptr_q] <= (tag_idx_q[RD_LAT-1] == K_LAST);
        end
    end

    always_comb begin
        read_addr1_o   = (BITREV != 0) ? bitrev(k_q) : k_q;
        read_addr2_o   = read_addr1_o;
        m_if.m_valid   = (count_q != '0);
        m_if.m_data    = data_q[rd_ptr_q];
        m_if.m_index   = idx_q[rd_ptr_q];
        m_if.m_last    = last_q[rd_ptr_q];
        abort_o        = abort_q;
    end

endmodule

// File: tb/tb_fft_result_reader.sv
// Directed bench for fft_result_reader: three N=8 instances (natural, bit-reversed, RD_LAT=3)
// fed by latency-accurate result-memory models holding {k, ~k} at address k.
module tb_fft_result_reader;
    localparam int LV = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start1, start2;
    logic fft_done, fft_busy, m_ready;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    fft_result_reader_if #(.LEVEL(LV)) if0 ();
    fft_result_reader_if #(.LEVEL(LV)) if1 ();
    fft_result_reader_if #(.LEVEL(LV)) if2 ();
    assign if0.m_ready = m_ready;
    assign if1.m_ready = m_ready;
    assign if2.m_ready = m_ready;

    logic          re0, re1, re2, busy0, busy1, busy2, ab0, ab1, ab2;
    logic [LV-1:0] a10, a20, a11, a21, a12, a22;
    logic [63:0]   d0, d1, d2;
    logic [63:0]   pipe2 [2];

    function automatic logic [63:0] word(input logic [LV-1:0] a);
        logic [31:0] w;
        w = 32'(a);
        return {w, ~w};
    endfunction

    function automatic logic [LV-1:0] rev3(input int k);
        case (k)
            0: return 3'd0;  1: return 3'd4;  2: return 3'd2;  3: return 3'd6;
            4: return 3'd1;  5: return 3'd5;  6: return 3'd3;  default: return 3'd7;
        endcase
    endfunction

    always @(posedge clk) begin
        d0       <= word(a10);
        d1       <= word(a11);
        pipe2[0] <= word(a12);
        pipe2[1] <= pipe2[0];
        d2       <= pipe2[1];
    end

    fft_result_reader #(.N(8), .RD_LAT(1), .FIFO_DEPTH(4), .BITREV(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start_i(start0), .fft_done_i(fft_done), .fft_busy_i(fft_busy),
        .read_en_o(re0), .read_addr1_o(a10), .read_addr2_o(a20), .fft_data_i(d0),
        .m_if(if0), .busy_o(busy0), .abort_o(ab0));

    fft_result_reader #(.N(8), .RD_LAT(1), .FIFO_DEPTH(4), .BITREV(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start_i(start1), .fft_done_i(fft_done), .fft_busy_i(fft_busy),
        .read_en_o(re1), .read_addr1_o(a11), .read_addr2_o(a21), .fft_data_i(d1),
        .m_if(if1), .busy_o(busy1), .abort_o(ab1));

    fft_result_reader #(.N(8), .RD_LAT(3), .FIFO_DEPTH(4), .BITREV(0)) u2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .fft_done_i(fft_done), .fft_busy_i(fft_busy),
        .read_en_o(re2), .read_addr1_o(a12), .read_addr2_o(a22), .fft_data_i(d2),
        .m_if(if2), .busy_o(busy2), .abort_o(ab2));

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        compared++;
        if ({re0, busy0, ab0, if0.m_valid, if0.m_last, a10, a20, if0.m_index, if0.m_data} !== '0) begin
            mismatched++;
            $display("FAIL reset_u0: got re=%b busy=%b abort=%b valid=%b data=%h, expected all 0",
                     re0, busy0, ab0, if0.m_valid, if0.m_data);
        end
        compared++;
        if ({re1, busy1, ab1, if1.m_valid, if1.m_last, a11, a21, if1.m_index, if1.m_data} !== '0) begin
            mismatched++;
            $display("FAIL reset_u1: got re=%b busy=%b abort=%b valid=%b, expected all 0",
                     re1, busy1, ab1, if1.m_valid);
        end
        compared++;
        if ({re2, busy2, ab2, if2.m_valid, if2.m_last, a12, a22, if2.m_index, if2.m_data} !== '0) begin
            mismatched++;
            $display("FAIL reset_u2: got re=%b busy=%b abort=%b valid=%b, expected all 0",
                     re2, busy2, ab2, if2.m_valid);
        end
    endtask

    task automatic test_natural();
        int beat = 0;
        fft_done = 1'b1; fft_busy = 1'b0; m_ready = 1'b1;
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 8) begin
                compared++;
                if (a10 !== LV'(c - 1) || a20 !== LV'(c - 1)) begin
                    mismatched++;
                    $display("FAIL nat_addr c%0d: got %0d/%0d expected %0d", c, a10, a20, c - 1);
                end
            end
            compared++;
            if ({re0, busy0} !== {2{c <= 10}}) begin
                mismatched++;
                $display("FAIL nat_busy c%0d: got re=%b busy=%b expected %b", c, re0, busy0, c <= 10);
            end
            compared++;
            if (if0.m_valid !== (c >= 3 && c <= 10)) begin
                mismatched++;
                $display("FAIL nat_valid c%0d: got %b expected %b", c, if0.m_valid, c >= 3 && c <= 10);
            end
            if (if0.m_valid === 1'b1) begin
                compared++;
                if (if0.m_index !== LV'(beat) || if0.m_data !== word(LV'(beat)) || if0.m_last !== (beat == 7)) begin
                    mismatched++;
                    $display("FAIL nat_beat c%0d: got idx=%0d data=%h last=%b expected idx=%0d data=%h last=%b",
                             c, if0.m_index, if0.m_data, if0.m_last, beat, word(LV'(beat)), beat == 7);
                end
                beat++;
            end
            tick();
        end
    endtask

    task automatic test_bitrev();
        int beat = 0;
        fft_done = 1'b1; fft_busy = 1'b0; m_ready = 1'b1;
        start1 = 1'b1; tick(); start1 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 8) begin
                compared++;
                if (re1 !== 1'b1 || a11 !== rev3(c - 1) || a21 !== rev3(c - 1)) begin
                    mismatched++;
                    $display("FAIL rev_addr c%0d: got %0d/%0d expected %0d", c, a11, a21, rev3(c - 1));
                end
            end
            compared++;
            if (if1.m_valid !== (c >= 3 && c <= 10)) begin
                mismatched++;
                $display("FAIL rev_valid c%0d: got %b expected %b", c, if1.m_valid, c >= 3 && c <= 10);
            end
            if (if1.m_valid === 1'b1) begin
                compared++;
                if (if1.m_index !== LV'(beat) || if1.m_data !== word(rev3(beat)) || if1.m_last !== (beat == 7)) begin
                    mismatched++;
                    $display("FAIL rev_beat c%0d: got idx=%0d data=%h expected idx=%0d data=%h",
                             c, if1.m_index, if1.m_data, beat, word(rev3(beat)));
                end
                beat++;
            end
            tick();
        end
        compared++;
        if (busy1 !== 1'b0 || beat != 8) begin
            mismatched++;
            $display("FAIL rev_end: got busy=%b beats=%0d expected busy=0 beats=8", busy1, beat);
        end
    endtask

    task automatic test_backpressure();
        int            exp_idx = 0;
        logic          stalled = 1'b0;
        logic [63:0]   held_d  = '0;
        logic [LV-1:0] held_i  = '0;
        fft_done = 1'b1; fft_busy = 1'b0; m_ready = 1'b0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            m_ready = (c <= 6) ? (c % 2 == 1) : (c >= 17);
            if (stalled) begin
                compared++;
                if (if0.m_valid !== 1'b1 || if0.m_data !== held_d || if0.m_index !== held_i) begin
                    mismatched++;
                    $display("FAIL bp_stable c%0d: got v=%b idx=%0d data=%h expected v=1 idx=%0d data=%h",
                             c, if0.m_valid, if0.m_index, if0.m_data, held_i, held_d);
                end
            end
            if (c == 16) begin
                compared++;
                if (re0 !== 1'b1 || a10 !== 3'd6 || if0.m_index !== 3'd2) begin
                    mismatched++;
                    $display("FAIL bp_stall: got re=%b addr=%0d head=%0d expected re=1 addr=6 head=2",
                             re0, a10, if0.m_index);
                end
            end
            if (if0.m_valid === 1'b1 && m_ready) begin
                compared++;
                if (exp_idx >= 8 || if0.m_index !== LV'(exp_idx) || if0.m_data !== word(LV'(exp_idx))
                    || if0.m_last !== (exp_idx == 7)) begin
                    mismatched++;
                    $display("FAIL bp_beat c%0d: got idx=%0d data=%h expected idx=%0d data=%h",
                             c, if0.m_index, if0.m_data, exp_idx, word(LV'(exp_idx)));
                end
                exp_idx++;
            end
            stalled = (if0.m_valid === 1'b1) && !m_ready;
            held_d  = if0.m_data;
            held_i  = if0.m_index;
            tick();
        end
        compared++;
        if (exp_idx != 8 || busy0 !== 1'b0 || if0.m_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_end: got beats=%0d busy=%b valid=%b expected beats=8 busy=0 valid=0",
                     exp_idx, busy0, if0.m_valid);
        end
    endtask

    task automatic test_abort();
        int got = 0;
        fft_done = 1'b1; fft_busy = 1'b0; m_ready = 1'b1;
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (if0.m_valid === 1'b1 && m_ready) got++;
            tick();
        end
        compared++;
        if (got != 3) begin
            mismatched++;
            $display("FAIL abort_pre: got %0d beats expected 3", got);
        end
        fft_done = 1'b0; tick();
        compared++;
        if ({ab0, if0.m_valid, busy0, re0} !== 4'b1000) begin
            mismatched++;
            $display("FAIL abort_pulse: got abort=%b valid=%b busy=%b re=%b expected 1000",
                     ab0, if0.m_valid, busy0, re0);
        end
        tick();
        compared++;
        if ({ab0, if0.m_valid, busy0, re0} !== 4'b0000) begin
            mismatched++;
            $display("FAIL abort_clear: got abort=%b valid=%b busy=%b re=%b expected 0000",
                     ab0, if0.m_valid, busy0, re0);
        end
        fft_done = 1'b1;
        start0 = 1'b1; tick(); start0 = 1'b0;
        tick(); tick();
        compared++;
        if (if0.m_valid !== 1'b1 || if0.m_index !== 3'd0 || if0.m_data !== word(3'd0)) begin
            mismatched++;
            $display("FAIL abort_restart: got v=%b idx=%0d data=%h expected v=1 idx=0 data=%h",
                     if0.m_valid, if0.m_index, if0.m_data, word(3'd0));
        end
        fft_busy = 1'b1; tick();
        compared++;
        if ({ab0, if0.m_valid, busy0} !== 3'b100) begin
            mismatched++;
            $display("FAIL abort_busy: got abort=%b valid=%b busy=%b expected 100", ab0, if0.m_valid, busy0);
        end
        fft_busy = 1'b0; tick();
    endtask

    task automatic test_ignored_start();
        fft_done = 1'b0; fft_busy = 1'b0;
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            compared++;
            if ({busy0, re0} !== 2'b00) begin
                mismatched++;
                $display("FAIL ign_notdone c%0d: got busy=%b re=%b expected 00", c, busy0, re0);
            end
            tick();
        end
        fft_done = 1'b1; fft_busy = 1'b1;
        start0 = 1'b1; tick(); start0 = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            compared++;
            if ({busy0, re0} !== 2'b00) begin
                mismatched++;
                $display("FAIL ign_fftbusy c%0d: got busy=%b re=%b expected 00", c, busy0, re0);
            end
            tick();
        end
        fft_busy = 1'b0;
    endtask

    task automatic test_rdlat3();
        int beat = 0;
        fft_done = 1'b1; fft_busy = 1'b0; m_ready = 1'b1;
        start2 = 1'b1; tick(); start2 = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c <= 8) begin
                compared++;
                if (a12 !== LV'(c - 1)) begin
                    mismatched++;
                    $display("FAIL lat3_addr c%0d: got %0d expected %0d", c, a12, c - 1);
                end
            end
            compared++;
            if ({re2, busy2} !== {2{c <= 12}} || if2.m_valid !== (c >= 5 && c <= 12)) begin
                mismatched++;
                $display("FAIL lat3_ctrl c%0d: got re=%b busy=%b valid=%b expected %b/%b/%b",
                         c, re2, busy2, if2.m_valid, c <= 12, c <= 12, c >= 5 && c <= 12);
            end
            if (if2.m_valid === 1'b1) begin
                compared++;
                if (if2.m_index !== LV'(beat) || if2.m_data !== word(LV'(beat)) || if2.m_last !== (beat == 7)) begin
                    mismatched++;
                    $display("FAIL lat3_beat c%0d: got idx=%0d data=%h expected idx=%0d data=%h",
                             c, if2.m_index, if2.m_data, beat, word(LV'(beat)));
                end
                beat++;
            end
            tick();
        end
        start2 = 1'b1; tick(); start2 = 1'b0;
        repeat (5) tick();
        compared++;
        if (if2.m_valid !== 1'b1 || busy2 !== 1'b1) begin
            mismatched++;
            $display("FAIL lat3_middrain: got valid=%b busy=%b expected 1/1", if2.m_valid, busy2);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({re2, busy2, ab2, if2.m_valid, if2.m_last, a12, a22, if2.m_index, if2.m_data} !== '0) begin
            mismatched++;
            $display("FAIL lat3_asyncrst: got re=%b busy=%b valid=%b idx=%0d data=%h expected all 0",
                     re2, busy2, if2.m_valid, if2.m_index, if2.m_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            compared++;
            if ({if2.m_valid, busy2, re2} !== 3'b000) begin
                mismatched++;
                $display("FAIL lat3_postrst c%0d: got valid=%b busy=%b re=%b expected 000",
                         c, if2.m_valid, busy2, re2);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        fft_done = 1'b0; fft_busy = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        tick();
        test_natural();
        test_bitrev();
        test_backpressure();
        test_abort();
        test_ignored_start();
        test_rdlat3();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
